// File: rtl/tx_arbiter.sv
// Round-robin owner of the shared UART byte transmitter; a grant is held for a whole frame.
// Build with TX_ARB_WATCHDOG_EN to revoke grants from owners that go silent for MAX_IDLE cycles.
module tx_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int MAX_IDLE = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   req_send,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   req_busy,
  input  logic                 tx_busy,
  output logic                 send,
  output logic [7:0]           tx_data,
  output logic                 timeout
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;

  state_t             state, state_nxt;
  logic [IW-1:0]      g, g_nxt, g_inc, rr_ptr, rr_nxt, pick;
  logic [NUM_REQ-1:0] grant_nxt, mask, eligible;
  logic               pick_vld;
  logic               wd_fire;

  assign eligible = req & ~mask;
  assign g_inc    = (int'(g) == NUM_REQ - 1) ? '0 : g + IW'(1);

  // Scan downward so the index closest to rr_ptr is the last one written.
  always_comb begin
    int idx;
    idx      = 0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (eligible[IW'(idx)]) begin
        pick     = IW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  assign send     = (state == GRANT) && req_send[g] && !tx_busy;
  assign tx_data  = send ? req_data[int'(g)*8 +: 8] : 8'h00;
  assign req_busy = {NUM_REQ{tx_busy}} | ~grant;

  always_comb begin
    state_nxt = state;
    g_nxt     = g;
    rr_nxt    = rr_ptr;
    grant_nxt = grant;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt = GRANT;
          g_nxt     = pick;
          grant_nxt = NUM_REQ'(1) << pick;
        end
      end
      GRANT: begin
        if (!req[g] || wd_fire) begin
          state_nxt = DRAIN;
          rr_nxt    = g_inc;
          grant_nxt = '0;
        end
      end
      DRAIN: begin
        grant_nxt = '0;
        if (!tx_busy) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      g      <= '0;
      rr_ptr <= '0;
      grant  <= '0;
    end else begin
      state  <= state_nxt;
      g      <= g_nxt;
      rr_ptr <= rr_nxt;
      grant  <= grant_nxt;
    end
  end

`ifdef TX_ARB_WATCHDOG_EN
  localparam int CW = $clog2(MAX_IDLE + 1);

  logic [CW-1:0] idle_cnt;

  // Only a still-requesting owner can time out; a falling req is a normal release.
  assign wd_fire = (state == GRANT) && req[g] && !send && (idle_cnt == CW'(MAX_IDLE - 1));
  assign timeout = wd_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
      mask     <= '0;
    end else begin
      if (state != GRANT || send) idle_cnt <= '0;
      else                        idle_cnt <= idle_cnt + CW'(1);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req[i]) mask[i] <= 1'b0;
      end
      if (wd_fire) mask[g] <= 1'b1;
    end
  end
`else
  assign wd_fire = 1'b0;
  assign timeout = 1'b0;
  assign mask    = '0;
`endif

endmodule
